lut_sweeper: RTL and testbench

Parametrised N-input boolean function unit: holds a programmable 2^N-entry truth table and either evaluates one input vector on request or sweeps every minterm in ascending order, streaming one registered result per cycle. It counts the minterms that evaluate to 1. It is the sequential, width-generic successor to the fixed 4-input function modules and their hand-written exhaustive benches, used as a self-sweeping function generator inside lab designs.

---
 rtl/lut_sweeper.sv | 150 +++++++++++++++
 tb/tb_lut_sweeper.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_sweeper.sv
// lut_sweeper: programmable N-input boolean function unit.
//   Holds a 2^N-entry truth table (bit i = f(minterm i)). In IDLE it either
//   evaluates one vector x (result on the next cycle) or, on start, streams
//   every minterm 0..2^N-1 in order, one registered result per cycle, while
//   counting the 1-results. A DONE cycle with a done pulse follows the last
//   minterm; stop aborts a sweep without a done pulse.
// Optional feature (macro LUT_SWEEPER_CHECK_EN): second "expected" table,
//   loaded with cfg_sel=1; err counts streamed minterms where the function
//   table differs from it. Without the macro err is tied to 0.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears both tables)
//   cfg_we/sel/addr/data  table write port, honoured only in IDLE
//   start, stop, eval, x  sweep start / abort, single evaluation of x
//   s, idx, valid         registered result, its minterm, fresh-result flag
//   busy, done            sweep in progress, one-cycle end-of-sweep pulse
//   ones, err             N+1-bit counts of 1-results / expected mismatches
module lut_sweeper #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic         cfg_sel,
  input  logic [N-1:0] cfg_addr,
  input  logic         cfg_data,
  input  logic         start,
  input  logic         stop,
  input  logic         eval,
  input  logic [N-1:0] x,
  output logic         s,
  output logic [N-1:0] idx,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones,
  output logic [N:0]   err
);

  localparam int           DEPTH = 1 << N;
  localparam logic [N-1:0] LAST  = N'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t             r_state, w_next;
  logic [DEPTH-1:0]   r_tbl;
  logic               r_s, r_valid, r_done;
  logic [N-1:0]       r_idx;
  logic [N:0]         r_ones;
  logic [N-1:0]       w_nxt;
  logic               w_cfg_ok;

  assign w_nxt    = r_idx + N'(1);
  assign w_cfg_ok = cfg_we && (r_state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state. In SWEEP, r_idx is the minterm currently on the outputs.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SWEEP;
      SWEEP:   if (stop) w_next = IDLE;
               else if (r_idx == LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Function table: writable only while idle, frozen during a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_tbl <= '0;
    else if (w_cfg_ok && !cfg_sel) r_tbl[cfg_addr] <= cfg_data;
  end

  // Result datapath. ones accumulates the result currently shown, so the
  // count covers exactly the valid cycles, including the one in which stop
  // is sampled, and is final in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s     <= 1'b0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ones  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_s     <= r_tbl[0];
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_ones  <= '0;
          end else if (eval) begin
            r_s     <= r_tbl[x];
            r_idx   <= x;
            r_valid <= 1'b1;
          end
        end
        SWEEP: begin
          r_ones <= r_ones + (N+1)'(r_s);
          if (!stop) begin
            if (r_idx == LAST) begin
              r_done <= 1'b1;
            end else begin
              r_s     <= r_tbl[w_nxt];
              r_idx   <= w_nxt;
              r_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LUT_SWEEPER_CHECK_EN
  logic [DEPTH-1:0] r_exp;
  logic [N:0]       r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_exp <= '0;
    else if (w_cfg_ok && cfg_sel) r_exp[cfg_addr] <= cfg_data;
  end

  // Same accounting as ones: compare the minterm currently shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_err <= '0;
    else if (r_state == IDLE && start)      r_err <= '0;
    else if (r_state == SWEEP)              r_err <= r_err + (N+1)'(r_s ^ r_exp[r_idx]);
  end

  assign err = r_err;
`else
  assign err = '0;
`endif

  assign s     = r_s;
  assign idx   = r_idx;
  assign valid = r_valid;
  assign done  = r_done;
  assign busy  = (r_state == SWEEP);
  assign ones  = r_ones;

endmodule

// File: tb/tb_lut_sweeper.sv
// Self-checking bench for lut_sweeper (N=4). Expected {idx,s} pairs are
// queued when a sweep/eval is launched and a monitor pops and compares them
// on every valid cycle; the scenario tasks check control/count outputs inline.
module tb_lut_sweeper;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n, cfg_we, cfg_sel, cfg_data, start, stop, eval;
  logic [N-1:0] cfg_addr, x;
  logic         s, valid, busy, done;
  logic [N-1:0] idx;
  logic [N:0]   ones, err;

  int n_chk = 0;
  int n_pass = 0;
  bit fin = 1'b0;
  logic [4:0] q[$];

  lut_sweeper #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .stop(stop),
    .eval(eval), .x(x), .s(s), .idx(idx), .valid(valid), .busy(busy),
    .done(done), .ones(ones), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tbl(input logic [15:0] v, input logic sel);
    for (int i = 0; i < 16; i++) begin
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 4'(i); cfg_data = v[i];
      tick();
    end
    cfg_we = 1'b0; cfg_sel = 1'b0;
  endtask

  // Full sweep of table tv; start sampled at the first tick (edge 0).
  // If we_mid, a function-table write is attempted during the sweep.
  task automatic run_sweep(input logic [15:0] tv, input logic [N:0] exp_err,
                           input bit we_mid);
    logic [N:0] exp_ones;
    exp_ones = (N+1)'($countones(tv));
    for (int i = 0; i < 16; i++) q.push_back({4'(i), tv[i]});
    start = 1'b1;
    tick();
    start = 1'b0; eval = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_chk++;
      if (valid !== 1'b1 || busy !== 1'b1)
        $display("FAIL sweep_vb c=%0d valid=%b busy=%b need 1/1", c, valid, busy);
      else n_pass++;
      if (we_mid && c == 3) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd12; cfg_data = ~tv[12];
      end
      if (we_mid && c == 6) cfg_we = 1'b0;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL sweep_done done=%b valid=%b busy=%b need 1/0/0", done, valid, busy);
    else n_pass++;
    n_chk++;
    if (ones !== exp_ones) $display("FAIL sweep_ones got %0d need %0d", ones, exp_ones);
    else n_pass++;
    n_chk++;
    if (err !== exp_err) $display("FAIL sweep_err got %0d need %0d", err, exp_err);
    else n_pass++;
    tick();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL sweep_idle done=%b busy=%b need 0/0", done, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = 1'b0;
    start = 1'b0; stop = 1'b0; eval = 1'b0; x = '0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({s, idx, valid, busy, done, ones, err} !== '0)
      $display("FAIL reset_state s=%b idx=%0d v=%b b=%b d=%b ones=%0d err=%0d need all 0",
               s, idx, valid, busy, done, ones, err);
    else n_pass++;
    tick();
    // mid-sweep asynchronous reset
    load_tbl(16'h00FF, 1'b0);
    for (int i = 0; i < 16; i++) q.push_back({4'(i), i < 8});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s, idx, valid, busy, done, ones, err} !== '0)
      $display("FAIL reset_mid s=%b idx=%0d v=%b b=%b d=%b ones=%0d err=%0d need all 0",
               s, idx, valid, busy, done, ones, err);
    else n_pass++;
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep(16'h0000, '0, 1'b0);
  endtask

  task automatic test_sweep();
    load_tbl(16'h00FF, 1'b0);
    run_sweep(16'h00FF, '0, 1'b0);
    load_tbl(16'hFFFF, 1'b0);
    run_sweep(16'hFFFF, '0, 1'b1);
    // the dropped write must not have changed the table either
    run_sweep(16'hFFFF, '0, 1'b0);
    load_tbl(16'h8421, 1'b0);
    run_sweep(16'h8421, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_tbl(16'hA5C3, 1'b0);
    run_sweep(16'hA5C3, '0, 1'b0);
    run_sweep(16'hA5C3, '0, 1'b0);
  endtask

  task automatic test_stop();
    load_tbl(16'h00FF, 1'b0);
    for (int i = 0; i < 6; i++) q.push_back({4'(i), 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0)
      $display("FAIL stop_ctrl busy=%b valid=%b done=%b need 0/0/0", busy, valid, done);
    else n_pass++;
    n_chk++;
    if (ones !== 5'd6) $display("FAIL stop_ones got %0d need 6", ones);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL stop_nodone done=%b busy=%b need 0/0", done, busy);
      else n_pass++;
    end
    run_sweep(16'h00FF, '0, 1'b0);
  endtask

  task automatic test_eval();
    logic [N:0] o_prev;
    load_tbl(16'h0400, 1'b0);
    o_prev = ones;
    x = 4'b1010; eval = 1'b1;
    q.push_back({4'd10, 1'b1});
    tick();
    eval = 1'b0;
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b1 || s !== 1'b1 || idx !== 4'd10)
      $display("FAIL eval_hit valid=%b s=%b idx=%0d need 1/1/10", valid, s, idx);
    else n_pass++;
    n_chk++;
    if (ones !== o_prev) $display("FAIL eval_ones got %0d need %0d", ones, o_prev);
    else n_pass++;
    x = 4'b0011; eval = 1'b1;
    q.push_back({4'd3, 1'b0});
    tick();
    eval = 1'b0;
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b1 || s !== 1'b0 || idx !== 4'd3)
      $display("FAIL eval_miss valid=%b s=%b idx=%0d need 1/0/3", valid, s, idx);
    else n_pass++;
    tick();
    n_chk++;
    if (valid !== 1'b0 || idx !== 4'd3)
      $display("FAIL eval_hold valid=%b idx=%0d need 0/3", valid, idx);
    else n_pass++;
    // start wins over eval: stream must begin at idx 0
    x = 4'b1010; eval = 1'b1;
    run_sweep(16'h0400, '0, 1'b0);
  endtask

  task automatic test_check();
    load_tbl(16'h00FF, 1'b0);
    load_tbl(16'h00F8, 1'b1);
`ifdef LUT_SWEEPER_CHECK_EN
    run_sweep(16'h00FF, 5'd3, 1'b0);
`else
    run_sweep(16'h00FF, 5'd0, 1'b0);
`endif
  endtask

  initial begin
    fork
      begin : monitor
        logic [4:0] e;
        while (!fin) begin
          @(negedge clk);
          if (rst_n === 1'b1 && valid === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
              $display("FAIL sb_extra unexpected result idx=%0d s=%b", idx, s);
            end else begin
              e = q.pop_front();
              if ({idx, s} !== e)
                $display("FAIL sb_data got idx=%0d s=%b need idx=%0d s=%b",
                         idx, s, e[4:1], e[0]);
              else n_pass++;
            end
          end
        end
      end
      begin : tests
        test_reset();
        test_sweep();
        test_back_to_back();
        test_stop();
        test_eval();
        test_check();
        tick();
        n_chk++;
        if (q.size() != 0) $display("FAIL sb_left %0d results never produced", q.size());
        else n_pass++;
        fin = 1'b1;
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
